mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the multi-cycle MIPS core's single unified instruction/data memory. It shares the memory between the CPU port (instruction fetch and load/store, driven by the controller's iord/memwrite path) and a DMA/loader port. Arbitration is round-robin. Each access runs through a fixed-latency access sequence. The block produces a stall signal that the controller uses to hold pcen and irwrite while the CPU waits.

---
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and fixed-latency sequencer sharing one unified memory
// between the CPU port and the DMA/loader port.
module mem_arbiter #(
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          owner_nx, mem_en_nx, mem_we_nx, busy_nx;
    logic          cpu_ack_nx, dma_ack_nx, grant_dma;
    logic [AW-1:0] mem_addr_nx;
    logic [DW-1:0] mem_wdata_nx, cpu_rdata_nx, dma_rdata_nx;

    assign cpu_stall = cpu_req & ~cpu_ack;

    // DMA wins only when the CPU is idle or the CPU held the last grant
    assign grant_dma = dma_req & (~cpu_req | ~owner);

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        owner_nx     = owner;
        mem_en_nx    = 1'b0;
        mem_we_nx    = mem_we;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
        cpu_ack_nx   = 1'b0;
        dma_ack_nx   = 1'b0;
        cpu_rdata_nx = cpu_rdata;
        dma_rdata_nx = dma_rdata;

        case (state)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    owner_nx     = grant_dma;
                    mem_we_nx    = grant_dma ? dma_we    : cpu_we;
                    mem_addr_nx  = grant_dma ? dma_addr  : cpu_addr;
                    mem_wdata_nx = grant_dma ? dma_wdata : cpu_wdata;
                    mem_en_nx    = 1'b1;
                    state_nx     = ACCESS;
                end
            end
            ACCESS: begin
                cnt_nx   = CW'(LAT - 1);
                state_nx = WAIT;
            end
            WAIT: begin
                if (cnt == '0) begin
                    if (!mem_we) begin
                        if (owner) dma_rdata_nx = mem_rdata;
                        else       cpu_rdata_nx = mem_rdata;
                    end
                    cpu_ack_nx = ~owner;
                    dma_ack_nx = owner;
                    state_nx   = ACK;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            owner     <= 1'b1;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            owner     <= owner_nx;
            mem_en    <= mem_en_nx;
            mem_we    <= mem_we_nx;
            mem_addr  <= mem_addr_nx;
            mem_wdata <= mem_wdata_nx;
            cpu_ack   <= cpu_ack_nx;
            dma_ack   <= dma_ack_nx;
            cpu_rdata <= cpu_rdata_nx;
            dma_rdata <= dma_rdata_nx;
            busy      <= busy_nx;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed timing scenarios plus randomized
// traffic on both ports, checked against a reference memory model.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned LAT = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          cpu_req, cpu_we, cpu_ack, cpu_stall;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          dma_req, dma_we, dma_ack;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rdata;
    logic          mem_en, mem_we, busy, owner;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    // second instance with LAT=4, CPU port only
    logic          q_cpu_req, q_cpu_we, q_cpu_ack, q_cpu_stall;
    logic [AW-1:0] q_cpu_addr, q_dma_addr, q_mem_addr;
    logic [DW-1:0] q_cpu_wdata, q_cpu_rdata, q_dma_wdata, q_dma_rdata;
    logic          q_dma_req, q_dma_we, q_dma_ack;
    logic          q_mem_en, q_mem_we, q_busy, q_owner;
    logic [DW-1:0] q_mem_wdata, q_mem_rdata;

    mem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    mem_arbiter #(.AW(AW), .DW(DW), .LAT(4)) dut4 (
        .clk(clk), .reset(reset),
        .cpu_req(q_cpu_req), .cpu_we(q_cpu_we), .cpu_addr(q_cpu_addr), .cpu_wdata(q_cpu_wdata),
        .cpu_ack(q_cpu_ack), .cpu_rdata(q_cpu_rdata), .cpu_stall(q_cpu_stall),
        .dma_req(q_dma_req), .dma_we(q_dma_we), .dma_addr(q_dma_addr), .dma_wdata(q_dma_wdata),
        .dma_ack(q_dma_ack), .dma_rdata(q_dma_rdata),
        .mem_en(q_mem_en), .mem_we(q_mem_we), .mem_addr(q_mem_addr), .mem_wdata(q_mem_wdata),
        .mem_rdata(q_mem_rdata), .busy(q_busy), .owner(q_owner)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference memory and per-port expected responses
    typedef struct {
        logic          we;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          cpu_q[$];
    exp_t          dma_q[$];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] bus_mem [logic [AW-1:0]];
    logic [DW-1:0] last_cpu_rd = '0;
    logic [DW-1:0] last_dma_rd = '0;

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return 32'h5A00_0000 ^ (a * 32'h9E37_79B1);
    endfunction

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [DW-1:0] bus_read(input logic [AW-1:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
    endfunction

    task automatic push_exp(input logic port, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd);
        exp_t e;
        e.we = we;
        if (we) begin
            ref_mem[a] = wd;
            e.data = port ? last_dma_rd : last_cpu_rd;
        end else begin
            e.data = ref_read(a);
            if (port) last_dma_rd = e.data;
            else      last_cpu_rd = e.data;
        end
        if (port) dma_q.push_back(e);
        else      cpu_q.push_back(e);
    endtask

    task automatic drive(input logic port, input logic req, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd);
        if (port) begin
            dma_req = req; dma_we = we; dma_addr = a; dma_wdata = wd;
        end else begin
            cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        end
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // One full request/ack handshake on a port, request held until ack
    task automatic txn(input logic port, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd);
        bit done = 1'b0;
        push_exp(port, we, a, wd);
        drive(port, 1'b1, we, a, wd);
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if ((port ? dma_ack : cpu_ack) == 1'b1) done = 1'b1;
            align();
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_ack_timeout: no ack in 40 cycles, required one", port ? "dma" : "cpu");
        end
        drive(port, 1'b0, 1'($urandom), $urandom, $urandom);
    endtask

    // Memory device: writes land on the strobe, read data valid only LAT cycles later
    int            cyc    = 0;
    int            rd_due = -1;
    logic [AW-1:0] rd_addr = '0;

    always @(posedge clk) begin
        cyc++;
        if (mem_en) begin
            if (mem_we) bus_mem[mem_addr] = mem_wdata;
            else begin
                rd_due  = cyc + int'(LAT) - 1;
                rd_addr = mem_addr;
            end
        end
        #1 mem_rdata = (cyc == rd_due) ? bus_read(rd_addr) : $urandom;
    end

    // Monitor: pops the scoreboard on every ack and checks pulse shapes
    logic prev_en = 1'b0, prev_cack = 1'b0, prev_dack = 1'b0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (!reset) begin
            prev_en = 1'b0; prev_cack = 1'b0; prev_dack = 1'b0;
        end else begin
            check("cpu_stall", cpu_stall, cpu_req & ~cpu_ack);
            if (cpu_ack) begin
                check("cpu_ack_width", prev_cack, 1'b0);
                if (cpu_q.size() == 0) check("cpu_unexpected_ack", cpu_ack, 1'b0);
                else begin
                    mon_e = cpu_q.pop_front();
                    check(mon_e.we ? "cpu_rdata_after_write" : "cpu_rdata", cpu_rdata, mon_e.data);
                end
            end
            if (dma_ack) begin
                check("dma_ack_width", prev_dack, 1'b0);
                if (dma_q.size() == 0) check("dma_unexpected_ack", dma_ack, 1'b0);
                else begin
                    mon_e = dma_q.pop_front();
                    check(mon_e.we ? "dma_rdata_after_write" : "dma_rdata", dma_rdata, mon_e.data);
                end
            end
            if (mem_en) check("mem_en_width", prev_en, 1'b0);
            prev_en = mem_en; prev_cack = cpu_ack; prev_dack = dma_ack;
        end
    end

    // Per-cycle recording for the directed timing scenarios (bit k = cycle k)
    logic [15:0]   v_en, v_cack, v_dack, v_stall, v_busy, v_own;
    logic [DW-1:0] v_crd [16];
    logic [DW-1:0] v_drd [16];
    logic          cap_we;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_wdata;

    task automatic sample(input int n);
        v_en = '0; v_cack = '0; v_dack = '0; v_stall = '0; v_busy = '0; v_own = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            v_en[k] = mem_en; v_cack[k] = cpu_ack; v_dack[k] = dma_ack;
            v_stall[k] = cpu_stall; v_busy[k] = busy; v_own[k] = owner;
            v_crd[k] = cpu_rdata; v_drd[k] = dma_rdata;
            if (mem_en) begin
                cap_we = mem_we; cap_addr = mem_addr; cap_wdata = mem_wdata;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cpu_req = 1'b0; dma_req = 1'b0; q_cpu_req = 1'b0;
        cpu_q.delete(); dma_q.delete();
        last_cpu_rd = '0; last_dma_rd = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        align();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [7:0]    q_en, q_ack;
    logic [DW-1:0] q_rd;

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        q_cpu_req = 1'b0; q_cpu_we = 1'b0; q_cpu_addr = '0; q_cpu_wdata = '0;
        q_dma_req = 1'b0; q_dma_we = 1'b0; q_dma_addr = '0; q_dma_wdata = '0;
        q_mem_rdata = '0; mem_rdata = '0;
        ref_mem[32'h40] = 32'h2010_0005;
        bus_mem[32'h40] = 32'h2010_0005;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_mem_wdata", mem_wdata, '0);
        check("rst_owner", owner, 1'b1);
        check("rst_acks", {cpu_ack, dma_ack}, 2'b00);
        check("rst_rdata", {cpu_rdata, dma_rdata}, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        align();

        // lone CPU read, LAT=1
        fork
            txn(1'b0, 1'b0, 32'h40, '0);
            sample(5);
        join
        check("t1_mem_en", v_en[4:0], 5'b00010);
        check("t1_cpu_ack", v_cack[4:0], 5'b01000);
        check("t1_cpu_stall", v_stall[4:0], 5'b00111);
        check("t1_busy", v_busy[4:0], 5'b01110);
        check("t1_cpu_rdata", v_crd[3], 32'h2010_0005);
        align();

        // simultaneous requests from reset, both held
        do_reset();
        fork
            begin
                push_exp(1'b0, 1'b0, 32'h40, '0);
                push_exp(1'b1, 1'b0, 32'h100, '0);
                push_exp(1'b0, 1'b0, 32'h40, '0);
                drive(1'b0, 1'b1, 1'b0, 32'h40, '0);
                drive(1'b1, 1'b1, 1'b0, 32'h100, '0);
                repeat (12) align();
                cpu_req = 1'b0;
                dma_req = 1'b0;
            end
            sample(12);
        join
        check("t2_cpu_ack", v_cack[11:0], 12'h808);
        check("t2_dma_ack", v_dack[11:0], 12'h080);
        check("t2_owner", v_own[11:0], 12'h1E1);
        check("t2_dma_rdata", v_drd[7], init_word(32'h100));
        align();

        // DMA write then read-back
        fork
            txn(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
            sample(5);
        join
        check("t3_mem_en", v_en[4:0], 5'b00010);
        check("t3_mem_we", cap_we, 1'b1);
        check("t3_mem_addr", cap_addr, 32'h100);
        check("t3_mem_wdata", cap_wdata, 32'hDEAD_BEEF);
        check("t3_dma_ack", v_dack[4:0], 5'b01000);
        check("t3_dma_rdata", v_drd[3], init_word(32'h100));
        align();
        txn(1'b1, 1'b0, 32'h100, '0);

        // DMA dropped after grant, CPU pending from cycle 1
        fork
            begin
                push_exp(1'b1, 1'b0, 32'h104, '0);
                push_exp(1'b0, 1'b0, 32'h44, '0);
                drive(1'b1, 1'b1, 1'b0, 32'h104, '0);
                align();
                drive(1'b0, 1'b1, 1'b0, 32'h44, '0);
                align();
                drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h1234_5678);
                repeat (6) align();
                cpu_req = 1'b0;
            end
            sample(9);
        join
        check("t4_dma_ack", v_dack[8:0], 9'h008);
        check("t4_cpu_ack", v_cack[8:0], 9'h080);
        check("t4_mem_en", v_en[8:0], 9'h022);
        align();

        // async reset while in WAIT
        push_exp(1'b0, 1'b0, 32'h48, '0);
        drive(1'b0, 1'b1, 1'b0, 32'h48, '0);
        align();
        align();
        #2;
        reset = 1'b0;
        cpu_req = 1'b0;
        #1;
        check("t5_busy", busy, 1'b0);
        check("t5_mem_en", mem_en, 1'b0);
        check("t5_owner", owner, 1'b1);
        check("t5_cpu_rdata", cpu_rdata, '0);
        cpu_q.delete(); dma_q.delete();
        last_cpu_rd = '0; last_dma_rd = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        align();
        sample(6);
        check("t5_no_ack", {v_cack[5:0], v_dack[5:0]}, 12'h000);
        align();
        txn(1'b0, 1'b0, 32'h40, '0);

        // LAT=4 instance, CPU read
        q_cpu_addr = 32'h40;
        q_cpu_req  = 1'b1;
        q_en = '0; q_ack = '0; q_rd = '0;
        for (int k = 0; k < 8; k++) begin
            q_mem_rdata = (k == 5) ? 32'hCAFE_0004 : $urandom;
            @(negedge clk);
            q_en[k]  = q_mem_en;
            q_ack[k] = q_cpu_ack;
            if (q_cpu_ack) q_rd = q_cpu_rdata;
            align();
            if (k == 6) q_cpu_req = 1'b0;
        end
        check("t6_mem_en", q_en, 8'h02);
        check("t6_cpu_ack", q_ack, 8'h40);
        check("t6_cpu_rdata", q_rd, 32'hCAFE_0004);

        // randomized traffic; address ranges kept disjoint between ports
        fork
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 3)) align();
                txn(1'b0, 1'($urandom), AW'({$urandom_range(0, 31), 2'b00}), $urandom);
            end
            for (int j = 0; j < 40; j++) begin
                repeat ($urandom_range(0, 3)) align();
                txn(1'b1, 1'($urandom), AW'(32'h100 + {$urandom_range(0, 31), 2'b00}), $urandom);
            end
        join
        repeat (8) align();
        check("cpu_q_drained", 64'(cpu_q.size()), 64'd0);
        check("dma_q_drained", 64'(dma_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
